// File: rtl/ex_mem_reg_pkg.sv
// rtl/ex_mem_reg_pkg.sv - shared constants for the EX/MEM pipeline boundary
package ex_mem_reg_pkg;

   localparam int DW_DEFAULT = 16;
   localparam int RW_DEFAULT = 4;

   // Bit positions inside ex_flag_we, ordered {V,Z,N}
   localparam int FLAG_V = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 0;

   localparam logic [2:0] COND_NE  = 3'b000;
   localparam logic [2:0] COND_EQ  = 3'b001;
   localparam logic [2:0] COND_GT  = 3'b010;
   localparam logic [2:0] COND_LT  = 3'b011;
   localparam logic [2:0] COND_GTE = 3'b100;
   localparam logic [2:0] COND_LTE = 3'b101;
   localparam logic [2:0] COND_OV  = 3'b110;
   localparam logic [2:0] COND_UN  = 3'b111;

endpackage

// File: rtl/ex_mem_reg_branch_cond.sv
// rtl/ex_mem_reg_branch_cond.sv - branch condition evaluation against committed flags
module branch_cond
   import ex_mem_reg_pkg::*;
(
   input  logic [2:0] cond,
   input  logic       flagV,
   input  logic       flagZ,
   input  logic       flagN,
   output logic       condMet
);

   always_comb begin
      condMet = 1'b0;
      case (cond)
         COND_NE:  condMet = !flagZ;
         COND_EQ:  condMet = flagZ;
         COND_GT:  condMet = !flagZ && !flagN;
         COND_LT:  condMet = flagN;
         COND_GTE: condMet = flagZ || !flagN;
         COND_LTE: condMet = flagN || flagZ;
         COND_OV:  condMet = flagV;
         COND_UN:  condMet = 1'b1;
         default:  condMet = 1'b0;
      endcase
   end

endmodule

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with flag register and branch redirect
module ex_mem_reg
   import ex_mem_reg_pkg::*;
#(
   parameter int DW = DW_DEFAULT,
   parameter int RW = RW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          flush,
   input  logic          ex_valid,
   input  logic [DW-1:0] ex_alu_result,
   input  logic [DW-1:0] ex_add_result,
   input  logic          ex_v,
   input  logic          ex_z,
   input  logic          ex_n,
   input  logic [2:0]    ex_flag_we,
   input  logic          ex_is_branch,
   input  logic [2:0]    ex_cond,
   input  logic [DW-1:0] ex_p1,
   input  logic [RW-1:0] ex_dst,
   input  logic          ex_reg_we,
   input  logic          ex_mem_re,
   input  logic          ex_mem_we,
   input  logic          ex_hlt,
   output logic          mem_valid,
   output logic          mem_reg_we,
   output logic          mem_mem_re,
   output logic          mem_mem_we,
   output logic          mem_hlt,
   output logic [DW-1:0] mem_alu_result,
   output logic [DW-1:0] mem_store_data,
   output logic [RW-1:0] mem_dst,
   output logic          br_taken,
   output logic [DW-1:0] br_target,
   output logic          flag_v,
   output logic          flag_z,
   output logic          flag_n
);

   logic advance;
   logic squash;
   logic condMet;
   logic flagCommit;

   assign advance    = !stall;
   assign squash     = flush || !ex_valid;
   // Branches evaluate flags but never write them
   assign flagCommit = !squash && !ex_is_branch;

   // Uses committed flags: a setter in the previous cycle is already visible here
   branch_cond uBranchCond (
      .cond    (ex_cond),
      .flagV   (flag_v),
      .flagZ   (flag_z),
      .flagN   (flag_n),
      .condMet (condMet)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_valid      <= 1'b0;
         mem_reg_we     <= 1'b0;
         mem_mem_re     <= 1'b0;
         mem_mem_we     <= 1'b0;
         mem_hlt        <= 1'b0;
         mem_alu_result <= '0;
         mem_store_data <= '0;
         mem_dst        <= '0;
         br_taken       <= 1'b0;
         br_target      <= '0;
      end else if (advance) begin
         if (squash) begin
            mem_valid      <= 1'b0;
            mem_reg_we     <= 1'b0;
            mem_mem_re     <= 1'b0;
            mem_mem_we     <= 1'b0;
            mem_hlt        <= 1'b0;
            mem_alu_result <= '0;
            mem_store_data <= '0;
            mem_dst        <= '0;
            br_taken       <= 1'b0;
            br_target      <= '0;
         end else begin
            mem_valid      <= 1'b1;
            mem_reg_we     <= ex_reg_we;
            mem_mem_re     <= ex_mem_re;
            mem_mem_we     <= ex_mem_we;
            mem_hlt        <= ex_hlt;
            mem_alu_result <= ex_alu_result;
            mem_store_data <= ex_p1;
            mem_dst        <= ex_dst;
            br_taken       <= ex_is_branch && condMet;
            br_target      <= ex_add_result;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flag_v <= 1'b0;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
      end else if (advance && flagCommit) begin
         if (ex_flag_we[FLAG_V]) flag_v <= ex_v;
         if (ex_flag_we[FLAG_Z]) flag_z <= ex_z;
         if (ex_flag_we[FLAG_N]) flag_n <= ex_n;
      end
   end

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - scoreboard bench for ex_mem_reg against a behavioural model
module tb_ex_mem_reg;

   typedef struct packed {
      logic        valid;
      logic        regWe;
      logic        memRe;
      logic        memWe;
      logic        hlt;
      logic [15:0] alu;
      logic [15:0] storeData;
      logic [3:0]  dst;
      logic        brTaken;
      logic [15:0] brTarget;
      logic        v;
      logic        z;
      logic        n;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, stall, flush, ex_valid;
   logic [15:0] ex_alu_result, ex_add_result, ex_p1;
   logic        ex_v, ex_z, ex_n;
   logic [2:0]  ex_flag_we, ex_cond;
   logic        ex_is_branch;
   logic [3:0]  ex_dst;
   logic        ex_reg_we, ex_mem_re, ex_mem_we, ex_hlt;
   logic        mem_valid, mem_reg_we, mem_mem_re, mem_mem_we, mem_hlt;
   logic [15:0] mem_alu_result, mem_store_data, br_target;
   logic [3:0]  mem_dst;
   logic        br_taken, flag_v, flag_z, flag_n;

   int   tests = 0;
   int   fails = 0;
   exp_t model = '0;
   exp_t expQ[$];
   string tagQ[$];

   always #5 clk = ~clk;

   ex_mem_reg dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
      .ex_alu_result(ex_alu_result), .ex_add_result(ex_add_result),
      .ex_v(ex_v), .ex_z(ex_z), .ex_n(ex_n), .ex_flag_we(ex_flag_we),
      .ex_is_branch(ex_is_branch), .ex_cond(ex_cond), .ex_p1(ex_p1), .ex_dst(ex_dst),
      .ex_reg_we(ex_reg_we), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_hlt(ex_hlt),
      .mem_valid(mem_valid), .mem_reg_we(mem_reg_we), .mem_mem_re(mem_mem_re),
      .mem_mem_we(mem_mem_we), .mem_hlt(mem_hlt), .mem_alu_result(mem_alu_result),
      .mem_store_data(mem_store_data), .mem_dst(mem_dst), .br_taken(br_taken),
      .br_target(br_target), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n)
   );

   // Branch truth table written out as the set of {V,Z,N} values that take each code
   function automatic logic taken(input logic [2:0] c, input logic v, input logic z, input logic n);
      logic [7:0] table8;
      logic [2:0] idx;
      idx = {v, z, n};
      case (c)
         3'd0: table8 = 8'b0011_0011; // Z clear
         3'd1: table8 = 8'b1100_1100; // Z set
         3'd2: table8 = 8'b0001_0001; // Z and N clear
         3'd3: table8 = 8'b1010_1010; // N set
         3'd4: table8 = 8'b1101_1101; // Z set or N clear
         3'd5: table8 = 8'b1110_1110; // N or Z set
         3'd6: table8 = 8'b1111_0000; // V set
         default: table8 = 8'hFF;
      endcase
      return table8[idx];
   endfunction

   task automatic randomizeInputs();
      ex_valid      = 1'($urandom);
      ex_alu_result = 16'($urandom);
      ex_add_result = 16'($urandom);
      ex_p1         = 16'($urandom);
      ex_v          = 1'($urandom);
      ex_z          = 1'($urandom);
      ex_n          = 1'($urandom);
      ex_flag_we    = 3'($urandom);
      ex_is_branch  = 1'($urandom);
      ex_cond       = 3'($urandom);
      ex_dst        = 4'($urandom);
      ex_reg_we     = 1'($urandom);
      ex_mem_re     = 1'($urandom);
      ex_mem_we     = 1'($urandom);
      ex_hlt        = 1'($urandom);
   endtask

   task automatic plainOp();
      randomizeInputs();
      ex_valid     = 1'b1;
      ex_is_branch = 1'b0;
      stall        = 1'b0;
      flush        = 1'b0;
   endtask

   // Advance the model by one edge, queue its prediction, then clock the DUT
   task automatic tick(input string tag);
      exp_t nx;
      nx = model;
      if (rst) begin
         nx = '0;
      end else if (!stall) begin
         if (flush || !ex_valid) begin
            nx.valid = 0; nx.regWe = 0; nx.memRe = 0; nx.memWe = 0; nx.hlt = 0;
            nx.alu = 0; nx.storeData = 0; nx.dst = 0; nx.brTaken = 0; nx.brTarget = 0;
         end else begin
            nx.valid     = 1;
            nx.regWe     = ex_reg_we;
            nx.memRe     = ex_mem_re;
            nx.memWe     = ex_mem_we;
            nx.hlt       = ex_hlt;
            nx.alu       = ex_alu_result;
            nx.storeData = ex_p1;
            nx.dst       = ex_dst;
            nx.brTaken   = ex_is_branch && taken(ex_cond, model.v, model.z, model.n);
            nx.brTarget  = ex_add_result;
            if (!ex_is_branch) begin
               if (ex_flag_we[2]) nx.v = ex_v;
               if (ex_flag_we[1]) nx.z = ex_z;
               if (ex_flag_we[0]) nx.n = ex_n;
            end
         end
      end
      model = nx;
      expQ.push_back(nx);
      tagQ.push_back(tag);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t act, ex;
      string tag;
      if (expQ.size() > 0) begin
         ex  = expQ.pop_front();
         tag = tagQ.pop_front();
         act = {mem_valid, mem_reg_we, mem_mem_re, mem_mem_we, mem_hlt, mem_alu_result,
                mem_store_data, mem_dst, br_taken, br_target, flag_v, flag_z, flag_n};
         tests++;
         if (act !== ex) begin
            fails++;
            $display("FAIL %s: got valid/we/re/mwe/hlt=%b%b%b%b%b alu=%h sd=%h dst=%h bt=%b tgt=%h vzn=%b%b%b, expected valid/we/re/mwe/hlt=%b%b%b%b%b alu=%h sd=%h dst=%h bt=%b tgt=%h vzn=%b%b%b",
                     tag, act.valid, act.regWe, act.memRe, act.memWe, act.hlt, act.alu, act.storeData,
                     act.dst, act.brTaken, act.brTarget, act.v, act.z, act.n,
                     ex.valid, ex.regWe, ex.memRe, ex.memWe, ex.hlt, ex.alu, ex.storeData,
                     ex.dst, ex.brTaken, ex.brTarget, ex.v, ex.z, ex.n);
         end
      end
   end

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      randomizeInputs();

      // Reset wins over random stall/flush/valid traffic
      for (int i = 0; i < 2; i++) begin
         randomizeInputs();
         stall = 1'($urandom);
         flush = 1'($urandom);
         tick("reset");
      end
      rst = 1'b0;
      randomizeInputs();
      ex_valid = 1'b0; stall = 1'b0; flush = 1'b0;
      tick("bubble_after_reset");

      // Full flag write, then partial Z-only write
      plainOp();
      ex_v = 1; ex_z = 0; ex_n = 1; ex_flag_we = 3'b111;
      tick("flag_commit_all");
      plainOp();
      ex_v = 0; ex_z = 1; ex_n = 0; ex_flag_we = 3'b010;
      tick("flag_commit_z_only");

      // Setter then branch in the very next cycle, taken and not taken
      for (int k = 0; k < 2; k++) begin
         plainOp();
         ex_z = 1; ex_flag_we = 3'b111;
         tick("b2b_setter");
         plainOp();
         ex_is_branch = 1; ex_cond = (k == 0) ? 3'b001 : 3'b000;
         ex_add_result = 16'h0040;
         tick(k == 0 ? "b2b_branch_eq" : "b2b_branch_ne");
      end

      // Stall holds data, flags and a pending redirect
      plainOp();
      ex_is_branch = 1; ex_cond = 3'b111; ex_alu_result = 16'h1234;
      tick("stall_load");
      for (int i = 0; i < 3; i++) begin
         plainOp();
         stall = 1; ex_flag_we = 3'b111;
         tick("stall_hold");
      end

      // Flush squashes a flag-setting store; stall overrides flush
      plainOp();
      ex_mem_we = 1; ex_flag_we = 3'b111; ex_v = ~model.v; ex_z = ~model.z; ex_n = ~model.n;
      flush = 1;
      tick("flush_store");
      plainOp();
      ex_flag_we = 3'b111;
      tick("refill");
      plainOp();
      stall = 1; flush = 1;
      tick("stall_and_flush");

      // Every condition code against every flag combination
      for (int c = 0; c < 8; c++) begin
         for (int f = 0; f < 8; f++) begin
            plainOp();
            ex_flag_we = 3'b111; ex_v = f[2]; ex_z = f[1]; ex_n = f[0];
            tick("sweep_setter");
            plainOp();
            ex_is_branch = 1; ex_cond = 3'(c);
            tick("sweep_branch");
         end
      end

      // Free-running random traffic
      for (int i = 0; i < 400; i++) begin
         randomizeInputs();
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 4) == 0);
         rst   = ($urandom_range(0, 60) == 0);
         tick("random");
      end
      rst = 0;

      for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
      if (expQ.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d predictions left unchecked, expected 0", expQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
